price_read_responder: RTL and testbench

- Read side of the product price/stock table: owns the table, accepts price and stock writes, and answers handshaked price queries.
- Writers are the change-price path and the restock path. The reader is the purchase/display path.
- Every completed query emits one log record to the machine log.
- Sits between the price/restock control modules and the purchase FSM.

---
 rtl/price_read_responder_pkg.sv | 33 +++
 rtl/price_read_responder_if.sv | 31 +++
 rtl/price_read_responder_product_table_store.sv | 52 +++++
 rtl/price_read_responder.sv | 118 +++++++++++
 tb/tb_price_read_responder.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/price_read_responder_pkg.sv
// Shared types and constants for the product price/stock read responder.
package price_read_responder_pkg;

    localparam int unsigned NUM_PRODUCTS = 5;
    localparam int unsigned CODE_W       = 3;
    localparam int unsigned PRICE_W      = 4;
    localparam int unsigned COUNT_W      = 4;

    localparam logic [1:0] LOG_OP_CHANGE_PRICE = 2'b11;
    localparam logic [1:0] LOG_OP_READ         = 2'b01;

    typedef logic [CODE_W-1:0]  code_t;
    typedef logic [PRICE_W-1:0] price_t;
    typedef logic [COUNT_W-1:0] count_t;

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_INVALID  = 2'b01,
        ST_SOLD_OUT = 2'b10
    } status_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_RESPOND,
        S_LOG
    } state_t;

    function automatic logic code_valid(input code_t code);
        return 32'(code) < NUM_PRODUCTS;
    endfunction

endpackage

// File: rtl/price_read_responder_if.sv
// Query request/response and machine-log signals between purchase FSM and responder.
interface price_read_responder_if;
    import price_read_responder_pkg::*;

    logic    req_valid;
    logic    req_ready;
    code_t   req_code;
    logic    rsp_valid;
    logic    rsp_ready;
    price_t  rsp_price;
    count_t  rsp_count;
    status_t rsp_status;
    logic    log_valid;
    logic [1:0] log_operator;
    logic    log_param1;
    code_t   log_param2;
    price_t  log_param3;

    modport master (
        output req_valid, req_code, rsp_ready,
        input  req_ready, rsp_valid, rsp_price, rsp_count, rsp_status,
        input  log_valid, log_operator, log_param1, log_param2, log_param3
    );

    modport slave (
        input  req_valid, req_code, rsp_ready,
        output req_ready, rsp_valid, rsp_price, rsp_count, rsp_status,
        output log_valid, log_operator, log_param1, log_param2, log_param3
    );

endinterface

// File: rtl/price_read_responder_product_table_store.sv
// Price/count register file with invalid-code masking and write-through read port.
module product_table_store
    import price_read_responder_pkg::*;
(
    input  logic   clock,
    input  logic   reset_n,
    input  logic   wr_en,
    input  code_t  wr_code,
    input  price_t wr_price,
    input  logic   stk_en,
    input  code_t  stk_code,
    input  count_t stk_count,
    input  code_t  rd_code,
    output logic   rd_hit,
    output price_t rd_price,
    output count_t rd_count
);

    price_t price_mem [NUM_PRODUCTS];
    count_t count_mem [NUM_PRODUCTS];

    // Out-of-range codes never match an entry index, so they fall through untouched.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_PRODUCTS; i++) begin
                price_mem[i] <= '0;
                count_mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_PRODUCTS; i++) begin
                if (wr_en && wr_code == CODE_W'(i))
                    price_mem[i] <= wr_price;
                if (stk_en && stk_code == CODE_W'(i))
                    count_mem[i] <= stk_count;
            end
        end
    end

    always_comb begin
        rd_hit   = 1'b0;
        rd_price = '0;
        rd_count = '0;
        for (int unsigned i = 0; i < NUM_PRODUCTS; i++) begin
            if (rd_code == CODE_W'(i)) begin
                rd_hit   = 1'b1;
                rd_price = (wr_en && wr_code == rd_code) ? wr_price : price_mem[i];
                rd_count = (stk_en && stk_code == rd_code) ? stk_count : count_mem[i];
            end
        end
    end

endmodule

// File: rtl/price_read_responder.sv
// Owns the product table and answers handshaked price queries, logging each one.
module price_read_responder
    import price_read_responder_pkg::*;
#(
    parameter logic [1:0] LOG_OP = LOG_OP_READ
) (
    input  logic   clock,
    input  logic   reset_n,
    input  logic   wr_en,
    input  code_t  wr_code,
    input  price_t wr_price,
    input  logic   stk_en,
    input  code_t  stk_code,
    input  count_t stk_count,
    price_read_responder_if.slave bus
);

    state_t  state, state_next;
    code_t   code_q;
    price_t  price_q;
    count_t  count_q;
    status_t status_q;
    logic    ok_q;
    logic    accept, load_rsp;
    logic    rd_hit;
    price_t  rd_price;
    count_t  rd_count;

    product_table_store u_store (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_code   (wr_code),
        .wr_price  (wr_price),
        .stk_en    (stk_en),
        .stk_code  (stk_code),
        .stk_count (stk_count),
        .rd_code   (code_q),
        .rd_hit    (rd_hit),
        .rd_price  (rd_price),
        .rd_count  (rd_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // req_ready is gated by reset_n so it drops while reset is held.
    always_comb begin
        state_next    = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.log_valid = 1'b0;
        accept        = 1'b0;
        load_rsp      = 1'b0;
        case (state)
            S_IDLE: begin
                bus.req_ready = reset_n;
                if (bus.req_valid && reset_n) begin
                    accept     = 1'b1;
                    state_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                load_rsp   = 1'b1;
                state_next = S_RESPOND;
            end
            S_RESPOND: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready)
                    state_next = S_LOG;
            end
            S_LOG: begin
                bus.log_valid = 1'b1;
                state_next    = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            code_q   <= '0;
            price_q  <= '0;
            count_q  <= '0;
            status_q <= ST_OK;
            ok_q     <= 1'b0;
        end else begin
            if (accept)
                code_q <= bus.req_code;
            if (load_rsp) begin
                if (!rd_hit) begin
                    price_q  <= '0;
                    count_q  <= '0;
                    status_q <= ST_INVALID;
                    ok_q     <= 1'b0;
                end else begin
                    price_q  <= rd_price;
                    count_q  <= rd_count;
                    status_q <= (rd_count == '0) ? ST_SOLD_OUT : ST_OK;
                    ok_q     <= (rd_count != '0);
                end
            end
        end
    end

    assign bus.rsp_price    = price_q;
    assign bus.rsp_count    = count_q;
    assign bus.rsp_status   = status_q;
    assign bus.log_operator = LOG_OP;
    assign bus.log_param1   = ok_q;
    assign bus.log_param2   = code_q;
    assign bus.log_param3   = price_q;

endmodule

// File: tb/tb_price_read_responder.sv
// Directed-vector bench for price_read_responder: table-driven queries plus multi-cycle cases.
module tb_price_read_responder;
    import price_read_responder_pkg::*;

    logic   clock = 1'b0;
    logic   reset_n;
    logic   wr_en;
    code_t  wr_code;
    price_t wr_price;
    logic   stk_en;
    code_t  stk_code;
    count_t stk_count;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    price_read_responder_if bus ();

    price_read_responder #(.LOG_OP(LOG_OP_READ)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_code   (wr_code),
        .wr_price  (wr_price),
        .stk_en    (stk_en),
        .stk_code  (stk_code),
        .stk_count (stk_count),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    typedef enum int {OP_WP, OP_WS, OP_WB, OP_Q} op_e;
    typedef struct {
        op_e        op;
        logic [2:0] code;
        logic [3:0] price;
        logic [3:0] count;
        logic [3:0] ep;
        logic [3:0] ec;
        logic [1:0] es;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(op_e op, logic [2:0] code, logic [3:0] price, logic [3:0] count,
                                logic [3:0] ep, logic [3:0] ec, logic [1:0] es);
        vec_t v;
        v.op = op; v.code = code; v.price = price; v.count = count;
        v.ep = ep; v.ec = ec; v.es = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input bit p, input bit s, input logic [2:0] code,
                            input logic [3:0] price, input logic [3:0] count);
        wr_en = p; wr_code = code; wr_price = price;
        stk_en = s; stk_code = code; stk_count = count;
        tick();
        wr_en = 1'b0; stk_en = 1'b0;
    endtask

    // Leaves the bench at #1 after edge N+1 (response should be visible).
    task automatic start_query(input logic [2:0] code, input bit fwd,
                               input logic [3:0] fp, input logic [3:0] fc);
        int unsigned n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("req_ready_before_query", 32'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_code  = code;
        tick();
        bus.req_valid = 1'b0;
        if (fwd) begin
            wr_en = 1'b1; wr_code = code; wr_price = fp;
            stk_en = 1'b1; stk_code = code; stk_count = fc;
        end
        check("lookup_rsp_valid", 32'(bus.rsp_valid), 0);
        check("lookup_req_ready", 32'(bus.req_ready), 0);
        tick();
        wr_en = 1'b0; stk_en = 1'b0;
    endtask

    task automatic check_rsp(input logic [2:0] code, input logic [3:0] ep,
                             input logic [3:0] ec, input logic [1:0] es);
        check("rsp_valid", 32'(bus.rsp_valid), 1);
        check("rsp_price", 32'(bus.rsp_price), 32'(ep));
        check("rsp_count", 32'(bus.rsp_count), 32'(ec));
        check("rsp_status", 32'(bus.rsp_status), 32'(es));
        check("rsp_req_ready", 32'(bus.req_ready), 0);
    endtask

    // Called at #1 after edge N+1 with rsp_ready set; consumes response and log.
    task automatic finish_query(input logic [2:0] code, input logic [3:0] ep, input logic [1:0] es);
        bus.rsp_ready = 1'b1;
        tick();
        check("log_valid", 32'(bus.log_valid), 1);
        check("log_operator", 32'(bus.log_operator), 32'(2'b01));
        check("log_param1", 32'(bus.log_param1), (es == 2'b00) ? 1 : 0);
        check("log_param2", 32'(bus.log_param2), 32'(code));
        check("log_param3", 32'(bus.log_param3), 32'(ep));
        check("log_rsp_valid", 32'(bus.rsp_valid), 0);
        tick();
        check("log_one_cycle", 32'(bus.log_valid), 0);
        check("idle_req_ready", 32'(bus.req_ready), 1);
    endtask

    task automatic query(input logic [2:0] code, input logic [3:0] ep,
                         input logic [3:0] ec, input logic [1:0] es);
        start_query(code, 1'b0, 4'd0, 4'd0);
        check_rsp(code, ep, ec, es);
        finish_query(code, ep, es);
    endtask

    initial begin
        int unsigned accepts[$];

        reset_n = 1'b0;
        wr_en = 1'b0; wr_code = '0; wr_price = '0;
        stk_en = 1'b0; stk_code = '0; stk_count = '0;
        bus.req_valid = 1'b0; bus.req_code = '0; bus.rsp_ready = 1'b1;

        vecs.push_back(mk(OP_Q,  3'd2, 4'd0,  4'd0,  4'd0,  4'd0,  2'b10));
        vecs.push_back(mk(OP_WP, 3'd3, 4'd7,  4'd0,  4'd0,  4'd0,  2'b00));
        vecs.push_back(mk(OP_WS, 3'd3, 4'd0,  4'd4,  4'd0,  4'd0,  2'b00));
        vecs.push_back(mk(OP_Q,  3'd3, 4'd0,  4'd0,  4'd7,  4'd4,  2'b00));
        vecs.push_back(mk(OP_Q,  3'd6, 4'd0,  4'd0,  4'd0,  4'd0,  2'b01));
        vecs.push_back(mk(OP_WP, 3'd0, 4'd1,  4'd0,  4'd0,  4'd0,  2'b00));
        vecs.push_back(mk(OP_WS, 3'd0, 4'd0,  4'd2,  4'd0,  4'd0,  2'b00));
        vecs.push_back(mk(OP_WB, 3'd1, 4'd2,  4'd3,  4'd0,  4'd0,  2'b00));
        vecs.push_back(mk(OP_WP, 3'd2, 4'd3,  4'd0,  4'd0,  4'd0,  2'b00));
        vecs.push_back(mk(OP_WB, 3'd4, 4'd15, 4'd15, 4'd0,  4'd0,  2'b00));
        vecs.push_back(mk(OP_WP, 3'd6, 4'd9,  4'd0,  4'd0,  4'd0,  2'b00));
        vecs.push_back(mk(OP_WS, 3'd7, 4'd0,  4'd9,  4'd0,  4'd0,  2'b00));
        vecs.push_back(mk(OP_WB, 3'd5, 4'd8,  4'd8,  4'd0,  4'd0,  2'b00));
        vecs.push_back(mk(OP_Q,  3'd0, 4'd0,  4'd0,  4'd1,  4'd2,  2'b00));
        vecs.push_back(mk(OP_Q,  3'd1, 4'd0,  4'd0,  4'd2,  4'd3,  2'b00));
        vecs.push_back(mk(OP_Q,  3'd2, 4'd0,  4'd0,  4'd3,  4'd0,  2'b10));
        vecs.push_back(mk(OP_Q,  3'd3, 4'd0,  4'd0,  4'd7,  4'd4,  2'b00));
        vecs.push_back(mk(OP_Q,  3'd4, 4'd0,  4'd0,  4'd15, 4'd15, 2'b00));
        vecs.push_back(mk(OP_Q,  3'd5, 4'd0,  4'd0,  4'd0,  4'd0,  2'b01));
        vecs.push_back(mk(OP_Q,  3'd7, 4'd0,  4'd0,  4'd0,  4'd0,  2'b01));

        #2;
        check("reset_req_ready", 32'(bus.req_ready), 0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 0);
        check("reset_log_valid", 32'(bus.log_valid), 0);
        check("reset_rsp_fields", {bus.rsp_price, bus.rsp_count, 22'(bus.rsp_status)}, 0);
        check("reset_log_params", {bus.log_param1, bus.log_param2, bus.log_param3}, 0);
        @(posedge clock); @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_WP: do_write(1'b1, 1'b0, vecs[i].code, vecs[i].price, vecs[i].count);
                OP_WS: do_write(1'b0, 1'b1, vecs[i].code, vecs[i].price, vecs[i].count);
                OP_WB: do_write(1'b1, 1'b1, vecs[i].code, vecs[i].price, vecs[i].count);
                default: query(vecs[i].code, vecs[i].ep, vecs[i].ec, vecs[i].es);
            endcase
        end

        // Hold the response for 5 cycles with a same-code price write in the middle.
        bus.rsp_ready = 1'b0;
        start_query(3'd3, 1'b0, 4'd0, 4'd0);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                wr_en = 1'b1; wr_code = 3'd3; wr_price = 4'd12;
            end
            check_rsp(3'd3, 4'd7, 4'd4, 2'b00);
            check("hold_no_log", 32'(bus.log_valid), 0);
            tick();
            wr_en = 1'b0;
        end
        finish_query(3'd3, 4'd7, 2'b00);
        query(3'd3, 4'd12, 4'd4, 2'b00);

        // Price and stock writes during LOOKUP are forwarded into the response.
        start_query(3'd1, 1'b1, 4'd5, 4'd9);
        check_rsp(3'd1, 4'd5, 4'd9, 2'b00);
        finish_query(3'd1, 4'd5, 2'b00);
        query(3'd1, 4'd5, 4'd9, 2'b00);

        // Back-to-back requests with rsp_ready held high.
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_code  = 3'd0;
        for (int k = 0; k < 14; k++) begin
            if (bus.req_ready === 1'b1)
                accepts.push_back(k + 1);
            tick();
        end
        bus.req_valid = 1'b0;
        check("b2b_accept_count", accepts.size(), 4);
        for (int k = 1; k < accepts.size(); k++)
            check("b2b_accept_spacing", accepts[k] - accepts[k-1], 4);
        query(3'd0, 4'd1, 4'd2, 2'b00);

        // Reset while a response is pending.
        bus.rsp_ready = 1'b0;
        start_query(3'd4, 1'b0, 4'd0, 4'd0);
        check_rsp(3'd4, 4'd15, 4'd15, 2'b00);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_rsp_valid", 32'(bus.rsp_valid), 0);
        check("midreset_req_ready", 32'(bus.req_ready), 0);
        check("midreset_rsp_price", 32'(bus.rsp_price), 0);
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("midreset_no_log", 32'(bus.log_valid), 0);
        end
        query(3'd4, 4'd0, 4'd0, 2'b10);
        query(3'd3, 4'd0, 4'd0, 2'b10);
        do_write(1'b1, 1'b1, 3'd2, 4'd6, 4'd1);
        query(3'd2, 4'd6, 4'd1, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
